// File: rtl/byte_stream_word_buffer_if.sv
// Byte-input / word-notify / drained-word-stream bundle around the word buffer.
// The buffer uses the slave modport; its driver or the bench uses master.
interface byte_stream_word_buffer_if #(
  parameter int WORD_W = 20,
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              word_ack;
  logic              flush;
  logic              word_received;
  logic              trans_start;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic [ADDR_W:0]   fill_count;
  logic              drop_err;
  logic              timeout_err;

  modport master (
    output byte_valid, byte_in, word_ack, flush, out_ready,
    input  word_received, trans_start, out_valid, out_data, out_last,
           fill_count, drop_err, timeout_err
  );

  modport slave (
    input  byte_valid, byte_in, word_ack, flush, out_ready,
    output word_received, trans_start, out_valid, out_data, out_last,
           fill_count, drop_err, timeout_err
  );
endinterface

// File: rtl/byte_stream_word_buffer.sv
// Packs UART bytes little-endian into words, stores them in a frame RAM and drains the frame
// as a valid/ready stream (2 cycles per word) when full or flushed; bytes outside COLLECT are dropped.
module byte_stream_word_buffer #(
  parameter int BYTES_PER_WORD = 3,
  parameter int WORD_W         = 20,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit ACK_EN         = 1'b1,
  parameter int TIMEOUT_CYC    = 0
) (
  input logic clk,
  input logic rst,
  byte_stream_word_buffer_if.slave bus
);
  localparam int K_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int T_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [K_W-1:0]  K_LAST = K_W'(BYTES_PER_WORD - 1);
  localparam logic [T_W-1:0]  T_LAST = T_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {COLLECT, WRITE, NOTIFY, DRAIN_RD, DRAIN_OUT} state_t;

  state_t            state;
  logic [K_W-1:0]    k;
  logic [T_W-1:0]    tmo_cnt;
  logic [WORD_W-1:0] assembled;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   fill;
  logic              word_received_q;
  logic              trans_start_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              drop_err_q;
  logic              timeout_err_q;

  logic [WORD_W-1:0] ram [DEPTH];
  logic [WORD_W-1:0] rd_word;

  // RAM and its read register carry no reset so they map onto block memory.
  always_ff @(posedge clk) begin
    if (state == WRITE)
      ram[wr_ptr] <= assembled;
    if (state == DRAIN_RD)
      rd_word <= ram[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= COLLECT;
      k               <= '0;
      tmo_cnt         <= '0;
      assembled       <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      word_received_q <= 1'b0;
      trans_start_q   <= 1'b0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      drop_err_q      <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      trans_start_q <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_err_q    <= bus.byte_valid && (state != COLLECT);

      case (state)
        COLLECT: begin
          if (bus.byte_valid) begin
            // Bits above WORD_W of the top byte are simply never stored.
            for (int i = 0; i < WORD_W; i++)
              if (int'(k) == i / 8)
                assembled[i] <= bus.byte_in[3'(i % 8)];
            tmo_cnt <= '0;
            if (k == K_LAST) begin
              k     <= '0;
              state <= WRITE;
            end else begin
              k <= k + 1'b1;
            end
          end else if (k != '0) begin
            if (TIMEOUT_CYC != 0 && tmo_cnt == T_LAST) begin
              k             <= '0;
              tmo_cnt       <= '0;
              timeout_err_q <= 1'b1;
            end else if (TIMEOUT_CYC != 0) begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else if (bus.flush && fill != '0) begin
            state         <= DRAIN_RD;
            trans_start_q <= 1'b1;
          end
        end

        WRITE: begin
          wr_ptr          <= wr_ptr + 1'b1;
          fill            <= fill + 1'b1;
          word_received_q <= 1'b1;
          state           <= NOTIFY;
        end

        NOTIFY: begin
          if (!ACK_EN || bus.word_ack) begin
            word_received_q <= 1'b0;
            if (fill == FULL) begin
              state         <= DRAIN_RD;
              trans_start_q <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end

        DRAIN_RD: begin
          out_valid_q <= 1'b1;
          out_last_q  <= ({1'b0, rd_ptr} == fill - 1'b1);
          state       <= DRAIN_OUT;
        end

        DRAIN_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              rd_ptr <= '0;
              wr_ptr <= '0;
              fill   <= '0;
              state  <= COLLECT;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
              state  <= DRAIN_RD;
            end
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.word_received = word_received_q;
  assign bus.trans_start   = trans_start_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_valid_q ? rd_word : '0;
  assign bus.out_last      = out_last_q;
  assign bus.fill_count    = fill;
  assign bus.drop_err      = drop_err_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_byte_stream_word_buffer.sv
// Randomised scoreboard bench: stimulus pushes expected drained words, a monitor pops and compares.
module tb_byte_stream_word_buffer;
  localparam int BPW   = 3;
  localparam int WW    = 20;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TMO   = 10;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  byte_stream_word_buffer_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

  byte_stream_word_buffer #(
    .BYTES_PER_WORD(BPW),
    .WORD_W(WW),
    .DEPTH(DEPTH),
    .ACK_EN(1'b1),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int fails = 0;
  exp_t exp_q[$];
  int stored[$];
  int part[BPW];
  int k_mod = 0;
  int exp_drop = 0, exp_tmo = 0, exp_starts = 0;
  int got_drop = 0, got_tmo = 0, got_starts = 0;

  bit            in_drain = 0;
  bit            prev_stall = 0;
  bit            prev_ts = 0;
  logic [WW-1:0] stall_data;
  logic          stall_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic int word_value();
    longint v = 0;
    longint m = 1;
    for (int i = 0; i < BPW; i++) begin
      v += longint'(part[i]) * m;
      m *= 256;
    end
    return int'(v % (longint'(1) << WW));
  endfunction

  task automatic put_byte(input logic [7:0] b, input logic fl, input logic ack);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    bus.flush      = fl;
    bus.word_ack   = ack;
    tick();
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ack   = 1'b0;
    part[k_mod] = b;
    k_mod++;
  endtask

  task automatic start_drain;
    exp_t e;
    for (int i = 0; i < stored.size(); i++) begin
      e.data = WW'(stored[i]);
      e.last = (i == stored.size() - 1);
      exp_q.push_back(e);
    end
    stored.delete();
    exp_starts++;
  endtask

  task automatic wait_drain;
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      if (bus.out_valid && $urandom_range(0, 3) == 0) begin
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'($urandom);
        exp_drop++;
      end
      tick();
      bus.byte_valid = 1'b0;
      budget--;
    end
    check("drain_complete", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("fill_count_after_drain", bus.fill_count, 0);
  endtask

  task automatic finish_word;
    @(negedge clk);
    check("word_received_early", bus.word_received, 0);
    tick();
    @(negedge clk);
    check("word_received_rise", bus.word_received, 1);
    check("fill_count_after_write", bus.fill_count, stored.size());
    repeat ($urandom_range(0, 3)) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'($urandom);
        exp_drop++;
      end
      tick();
      bus.byte_valid = 1'b0;
      @(negedge clk);
      check("word_received_held", bus.word_received, 1);
    end
    bus.word_ack = 1'b1;
    tick();
    bus.word_ack = 1'b0;
    @(negedge clk);
    check("word_received_clear", bus.word_received, 0);
    if (stored.size() == DEPTH) begin
      start_drain();
      wait_drain();
    end
  endtask

  // Completes the current word from byte index k_mod onward; raw holds byte i at bits [8i+7:8i].
  task automatic send_word(input logic [23:0] raw, input bit rnd);
    logic [7:0] b;
    for (int i = k_mod; i < BPW; i++) begin
      if (rnd) idle($urandom_range(0, 3));
      b = raw[8*i +: 8];
      put_byte(b, rnd && ($urandom_range(0, 3) == 0),
               rnd && (i < BPW - 1) && ($urandom_range(0, 3) == 0));
    end
    stored.push_back(word_value());
    k_mod = 0;
    finish_word();
  endtask

  task automatic do_flush;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    if (k_mod == 0 && stored.size() > 0) begin
      start_drain();
      wait_drain();
    end else begin
      idle(4);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_received"}, bus.word_received, 0);
    check({tag, "_trans_start"}, bus.trans_start, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
    check({tag, "_fill_count"}, bus.fill_count, 0);
    check({tag, "_drop_err"}, bus.drop_err, 0);
    check({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_drain   = 0;
        prev_stall = 0;
        prev_ts    = 0;
      end else begin
        if (bus.trans_start) got_starts++;
        if (bus.drop_err) got_drop++;
        if (bus.timeout_err) got_tmo++;
        if (bus.out_valid) begin
          if (!in_drain) begin
            check("trans_start_before_first_word", prev_ts, 1);
            in_drain = 1;
          end
          if (prev_stall) begin
            check("stall_data_stable", bus.out_data, stall_data);
            check("stall_last_stable", bus.out_last, stall_last);
          end
          if (bus.out_ready) begin
            prev_stall = 0;
            check("word_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("out_data", bus.out_data, e.data);
              check("out_last", bus.out_last, e.last);
              if (e.last) in_drain = 0;
            end
          end else begin
            prev_stall = 1;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
          end
        end else begin
          prev_stall = 0;
          check("out_data_idle_zero", bus.out_data, 0);
        end
        prev_ts = bus.trans_start;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached after %0d checks", checks);
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int n;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.word_ack   = 1'b0;
    bus.flush      = 1'b0;
    rst = 1'b1;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    send_word(24'hF54321, 0);

    put_byte(8'hAA, 1'b0, 1'b0);
    idle(9);
    @(negedge clk);
    check("timeout_not_yet", bus.timeout_err, 0);
    tick();
    @(negedge clk);
    check("timeout_pulse", bus.timeout_err, 1);
    exp_tmo++;
    k_mod = 0;
    send_word(24'h030201, 0);

    put_byte(8'h07, 1'b0, 1'b0);
    do_flush();
    send_word(24'h0C0B07, 0);
    do_flush();
    do_flush();

    repeat (30) begin
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 2)) put_byte(8'($urandom), 1'b0, 1'b0);
        idle(12);
        exp_tmo++;
        k_mod = 0;
      end
      send_word(24'($urandom), 1);
      if (stored.size() > 0 && $urandom_range(0, 3) == 0) do_flush();
    end

    while (stored.size() < 2) send_word(24'($urandom), 0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    start_drain();
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    check("drain_began", bus.out_valid, 1);
    #2 rst = 1'b1;
    exp_q.delete();
    stored.delete();
    k_mod = 0;
    #1;
    check_all_zero("mid_drain_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    send_word(24'h030201, 0);
    do_flush();

    idle(3);
    check("drop_err_count", got_drop, exp_drop);
    check("timeout_err_count", got_tmo, exp_tmo);
    check("trans_start_count", got_starts, exp_starts);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
